// File: rtl/cp_insert_ctrl.sv
// Cyclic-prefix insertion controller.
// Drives a two-bank ping-pong sample buffer: one symbol is written into the
// free bank while the other is read out as CP_LEN prefix samples (taken from
// the symbol tail) followed by the full N_FFT-sample body.
module cp_insert_ctrl #(
    parameter int N_FFT         = 1024,
    parameter int CP_LEN        = 32,
    parameter int SYM_PER_FRAME = 14,
    parameter int AW            = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          in_sop,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW:0]   wr_addr,
    output logic          rd_en,
    output logic [AW:0]   rd_addr,
    output logic          out_valid,
    output logic          out_sop,
    output logic          out_eop,
    output logic          out_cp,
    output logic [3:0]    sym_cnt,
    output logic          frame_done,
    output logic          err_overrun
);

    typedef enum logic [1:0] {IDLE, CP, BODY} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(N_FFT - 1);
    localparam logic [AW-1:0] CP_LAST  = AW'(CP_LEN - 1);
    localparam logic [AW-1:0] CP_BASE  = AW'(N_FFT - CP_LEN);
    localparam logic [3:0]    SYM_LAST = 4'(SYM_PER_FRAME - 1);

    state_t        state_q, state_d;
    logic [1:0]    full_q, full_d, full_set, full_clr, full_now;
    logic          wbank_q, wbank_d, rbank_q, rbank_d;
    logic          writing_q, writing_d;
    logic [AW-1:0] wcnt_q, wcnt_d, wr_ofs;
    logic [AW-1:0] rcnt_q, rcnt_d, cp_ofs;
    logic          err_q, err_d;
    logic          sop_now, eop_now;
    logic          out_valid_q, out_valid_d, out_sop_q, out_sop_d;
    logic          out_eop_q, out_eop_d, out_cp_q, out_cp_d;
    logic [3:0]    sym_cnt_q, sym_cnt_d;
    logic          frame_done_q, frame_done_d;

    // Write side: accept samples into the current write bank, detect restarts and overruns.
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wcnt_d    = wcnt_q;
        writing_d = writing_q;
        wbank_d   = wbank_q;
        err_d     = err_q;
        full_set  = 2'b00;
        wr_en     = 1'b0;
        in_ready  = !full_q[wbank_q];
        // A start-of-symbol always restarts at offset 0 of the same bank.
        wr_ofs    = in_sop ? '0 : wcnt_q;
        wr_addr   = {wbank_q, wr_ofs};
        if (en && !rst && in_valid) begin
            if (!in_ready) begin
                err_d = 1'b1;
            end else if (in_sop || writing_q) begin
                wr_en = 1'b1;
                if (in_sop && writing_q && wcnt_q != '0) begin
                    err_d = 1'b1;
                end
                if (wr_ofs == LAST_IDX) begin
                    full_set[wbank_q] = 1'b1;
                    wbank_d           = !wbank_q;
                    writing_d         = 1'b0;
                    wcnt_d            = '0;
                end else begin
                    writing_d = 1'b1;
                    wcnt_d    = wr_ofs + 1'b1;
                end
            end
        end
    end

    // Read FSM: prefix from the symbol tail, then the body; chains banks without idle cycles.
    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        rbank_d  = rbank_q;
        full_clr = 2'b00;
        rd_en    = 1'b0;
        sop_now  = 1'b0;
        eop_now  = 1'b0;
        // A bank completing this cycle counts as full so reading starts on the next cycle.
        full_now = full_q | full_set;
        cp_ofs   = CP_BASE + rcnt_q;
        rd_addr  = (state_q == CP) ? {rbank_q, cp_ofs} : {rbank_q, rcnt_q};
        if (en && !rst) begin
            unique case (state_q)
                IDLE: begin
                    if (full_now[rbank_q]) state_d = CP;
                end
                CP: begin
                    rd_en   = 1'b1;
                    sop_now = (rcnt_q == '0);
                    if (rcnt_q == CP_LAST) begin
                        state_d = BODY;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                BODY: begin
                    rd_en = 1'b1;
                    if (rcnt_q == LAST_IDX) begin
                        eop_now           = 1'b1;
                        full_clr[rbank_q] = 1'b1;
                        rbank_d           = !rbank_q;
                        rcnt_d            = '0;
                        state_d           = full_now[!rbank_q] ? CP : IDLE;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // Set and clear can land in the same cycle; both take effect.
        full_d = (full_q | full_set) & ~full_clr;
    end

    // Output flags: one-cycle delayed copies aligned with the RAM read data, frozen while en is low.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_sop_d    = out_sop_q;
        out_cp_d     = out_cp_q;
        out_eop_d    = out_eop_q;
        frame_done_d = frame_done_q;
        sym_cnt_d    = sym_cnt_q;
        if (en) begin
            out_valid_d  = rd_en;
            out_sop_d    = sop_now;
            out_cp_d     = (state_q == CP);
            out_eop_d    = eop_now;
            frame_done_d = eop_now && (sym_cnt_q == SYM_LAST);
            if (out_eop_q) begin
                sym_cnt_d = (sym_cnt_q == SYM_LAST) ? 4'd0 : sym_cnt_q + 4'd1;
            end
        end
    end

    // Read FSM state register.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q       <= 2'b00;
            wbank_q      <= 1'b0;
            rbank_q      <= 1'b0;
            writing_q    <= 1'b0;
            wcnt_q       <= '0;
            rcnt_q       <= '0;
            err_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            out_cp_q     <= 1'b0;
            sym_cnt_q    <= 4'd0;
            frame_done_q <= 1'b0;
        end else begin
            full_q       <= full_d;
            wbank_q      <= wbank_d;
            rbank_q      <= rbank_d;
            writing_q    <= writing_d;
            wcnt_q       <= wcnt_d;
            rcnt_q       <= rcnt_d;
            err_q        <= err_d;
            out_valid_q  <= out_valid_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            out_cp_q     <= out_cp_d;
            sym_cnt_q    <= sym_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_sop     = out_sop_q;
    assign out_eop     = out_eop_q;
    assign out_cp      = out_cp_q;
    assign sym_cnt     = sym_cnt_q;
    assign frame_done  = frame_done_q;
    assign err_overrun = err_q;

endmodule

// File: tb/tb_cp_insert_ctrl.sv
// Directed bench for cp_insert_ctrl with N_FFT=16, CP_LEN=4, SYM_PER_FRAME=3.
module tb_cp_insert_ctrl;

    localparam int N_FFT = 16;
    localparam int CP_LEN = 4;
    localparam int SPF = 3;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst, en, in_sop, in_valid;
    logic in_ready, wr_en, rd_en, out_valid, out_sop, out_eop, out_cp, frame_done, err_overrun;
    logic [AW:0] wr_addr, rd_addr;
    logic [3:0] sym_cnt;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int wr_q[$], wr_cyc[$], rd_q[$], rd_cyc[$], ov_cyc[$];
    logic [7:0] ov_q[$];
    int ir_drop_cyc = -1;
    int n_sop, n_cp, n_eop, n_fd;

    cp_insert_ctrl #(.N_FFT(N_FFT), .CP_LEN(CP_LEN), .SYM_PER_FRAME(SPF), .AW(AW)) dut (
        .clk(clk), .rst(rst), .en(en), .in_sop(in_sop), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
        .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_cp(out_cp),
        .sym_cnt(sym_cnt), .frame_done(frame_done), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle trace of strobes and output flags.
    always @(negedge clk) begin
        if (wr_en) begin wr_q.push_back(int'(wr_addr)); wr_cyc.push_back(cyc); end
        if (rd_en) begin rd_q.push_back(int'(rd_addr)); rd_cyc.push_back(cyc); end
        if (out_valid && en) begin
            ov_q.push_back({sym_cnt, frame_done, out_eop, out_cp, out_sop});
            ov_cyc.push_back(cyc);
        end
        if (!in_ready && ir_drop_cyc < 0) ir_drop_cyc = cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rd_at(int i);
        return (i < rd_q.size()) ? rd_q[i] : -1;
    endfunction

    function automatic int wr_at(int i);
        return (i < wr_q.size()) ? wr_q[i] : -1;
    endfunction

    function automatic int ov_at(int i);
        return (i < ov_q.size()) ? int'(ov_q[i]) : -1;
    endfunction

    task automatic clear_log();
        wr_q.delete(); wr_cyc.delete(); rd_q.delete(); rd_cyc.delete();
        ov_q.delete(); ov_cyc.delete();
        ir_drop_cyc = -1;
    endtask

    task automatic tally();
        n_sop = 0; n_cp = 0; n_eop = 0; n_fd = 0;
        foreach (ov_q[i]) begin
            n_sop += int'(ov_q[i][0]);
            n_cp  += int'(ov_q[i][1]);
            n_eop += int'(ov_q[i][2]);
            n_fd  += int'(ov_q[i][3]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_word(input logic sop);
        in_valid = 1'b1;
        in_sop   = sop;
        step();
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic send_symbol();
        for (int i = 0; i < N_FFT; i++) send_word(i == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_sop = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        clear_log();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_sop = 1'b0;
        step();
        step();
        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_sym_cnt", sym_cnt, 0);
        check("rst_flags", {out_sop, out_eop, out_cp, frame_done, err_overrun}, 0);
        rst = 1'b0;
        step();
        clear_log();

        // Single symbol
        send_symbol();
        idle(25);
        tally();
        check("t1_wr_n", wr_q.size(), 16);
        check("t1_wr_first", wr_at(0), 0);
        check("t1_wr_last", wr_at(15), 15);
        check("t1_rd_start", (rd_cyc.size() > 0 && wr_cyc.size() == 16) ? rd_cyc[0] - wr_cyc[15] : -1, 1);
        check("t1_rd_n", rd_q.size(), 20);
        check("t1_rd0", rd_at(0), 12);
        check("t1_rd3", rd_at(3), 15);
        check("t1_rd4", rd_at(4), 0);
        check("t1_rd19", rd_at(19), 15);
        check("t1_ov_n", ov_q.size(), 20);
        check("t1_sop0", ov_at(0) & 1, 1);
        check("t1_sop_n", n_sop, 1);
        check("t1_cp_n", n_cp, 4);
        check("t1_cp3", (ov_at(3) >> 1) & 1, 1);
        check("t1_cp4", (ov_at(4) >> 1) & 1, 0);
        check("t1_eop19", (ov_at(19) >> 2) & 1, 1);
        check("t1_eop_n", n_eop, 1);
        check("t1_fd_n", n_fd, 0);
        check("t1_sym_cnt", sym_cnt, 1);

        // Continuous input, three symbols (one frame)
        do_reset();
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < N_FFT; i++) begin
                g = 0;
                while (!in_ready && g < 200) begin idle(1); g++; end
                if (g >= 200) check("t2_ready_timeout", 0, 1);
                send_word(i == 0);
            end
        end
        idle(80);
        tally();
        check("t2_wr_n", wr_q.size(), 48);
        check("t2_ready_drop", (ir_drop_cyc >= 0 && wr_q.size() >= 32) ? ir_drop_cyc - wr_cyc[31] : -1, 1);
        check("t2_rd_n", rd_q.size(), 60);
        check("t2_rd20", rd_at(20), 28);
        check("t2_rd40", rd_at(40), 12);
        check("t2_ov_n", ov_q.size(), 60);
        check("t2_contig", (ov_cyc.size() == 60) ? ov_cyc[59] - ov_cyc[0] : -1, 59);
        check("t2_eop_n", n_eop, 3);
        check("t2_fd_n", n_fd, 1);
        check("t2_fd59", (ov_at(59) >> 3) & 1, 1);
        check("t2_sym19", (ov_at(19) >> 4) & 15, 0);
        check("t2_sym39", (ov_at(39) >> 4) & 15, 1);
        check("t2_sym59", (ov_at(59) >> 4) & 15, 2);
        check("t2_sym_wrap", sym_cnt, 0);
        check("t2_no_err", err_overrun, 0);

        // Restart mid-symbol
        do_reset();
        for (int i = 0; i < 7; i++) send_word(i == 0);
        send_symbol();
        idle(25);
        check("t3_err", err_overrun, 1);
        check("t3_wr_n", wr_q.size(), 23);
        check("t3_restart_addr", wr_at(7), 0);
        check("t3_last_addr", wr_at(22), 15);
        check("t3_rd_n", rd_q.size(), 20);
        check("t3_rd0", rd_at(0), 12);
        check("t3_rd4", rd_at(4), 0);

        // Stray samples and overrun
        do_reset();
        in_valid = 1'b1;
        in_sop   = 1'b0;
        repeat (3) step();
        in_valid = 1'b0;
        check("t4_stray_wr", wr_q.size(), 0);
        check("t4_stray_err", err_overrun, 0);
        send_symbol();
        send_symbol();
        check("t4_not_ready", in_ready, 0);
        in_valid = 1'b1;
        in_sop   = 1'b1;
        #1;
        check("t4_drop_wr_en", wr_en, 0);
        step();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        check("t4_err", err_overrun, 1);
        check("t4_wr_n", wr_q.size(), 32);

        // Clock-enable stall in the body
        do_reset();
        send_symbol();
        g = 0;
        while (rd_q.size() < 10 && g < 100) begin idle(1); g++; end
        check("t5_reach", rd_q.size(), 10);
        en = 1'b0;
        #1;
        check("t5_rd_en_off", rd_en, 0);
        check("t5_rd_addr", rd_addr, 6);
        idle(5);
        check("t5_rd_addr_held", rd_addr, 6);
        check("t5_ov_held", out_valid, 1);
        en = 1'b1;
        idle(30);
        tally();
        check("t5_rd_n", rd_q.size(), 20);
        check("t5_rd10", rd_at(10), 6);
        check("t5_rd19", rd_at(19), 15);
        check("t5_ov_n", ov_q.size(), 20);
        check("t5_eop_n", n_eop, 1);

        // Reset in the middle of the body
        do_reset();
        send_symbol();
        g = 0;
        while (!(rd_en && rd_addr == 9) && g < 100) begin idle(1); g++; end
        check("t6_reach", rd_addr, 9);
        rst = 1'b1;
        #1;
        check("t6_rd_en", rd_en, 0);
        check("t6_out_valid", out_valid, 0);
        check("t6_in_ready", in_ready, 1);
        check("t6_flags", {out_sop, out_eop, out_cp, frame_done, err_overrun, wr_en}, 0);
        step();
        rst = 1'b0;
        step();
        clear_log();
        idle(30);
        check("t6_quiet_rd", rd_q.size(), 0);
        check("t6_quiet_ov", ov_q.size(), 0);
        send_symbol();
        idle(25);
        check("t6_wr0", wr_at(0), 0);
        check("t6_rd_n", rd_q.size(), 20);
        check("t6_rd0", rd_at(0), 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
